membus_bridge: RTL

Parametrised device-bus bridge between the multi-cycle CPU core and up to N_DEV memory-mapped peripherals. It replaces the single fixed device port (one read/write strobe pair, zero-wait-state data) with per-device selects, a ready handshake with wait states, and a CPU stall output. The CPU-side decoder routes an access here only when the address is at or above DEV_BASE; data memory never passes through this block.

---
 rtl/membus_bridge_if.sv | 64 ++++++
 rtl/membus_bridge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/membus_bridge_if.sv
// ---------------------------------------------------------------------------
// membus_bridge bus interfaces
//
// cpu_bus_if : CPU-side device request bus.
//   master modport = CPU core (drives requests, receives stall/response)
//   slave  modport = bridge
//   valid/ready semantics: the CPU raises exactly one of cpu_read/cpu_write
//   and holds it, with address and data, for as long as cpu_stall is high.
//   The cycle with the request high and cpu_stall low is the completion
//   cycle; cpu_rdata/cpu_err are valid only then.
//
// dev_bus_if : bridge-to-peripheral bus.
//   master modport = bridge (selects, strobes, address offset, write data)
//   slave  modport = peripherals (per-slot read data and ready)
//   valid/ready semantics: dev_sel plus one strobe stay asserted and constant
//   until the selected slot raises its dev_ready bit; the access completes on
//   that clock edge and the strobes drop.
// ---------------------------------------------------------------------------
interface cpu_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              cpu_err;

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall, cpu_err
  );

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall, cpu_err
  );
endinterface

interface dev_bus_if #(
  parameter int N_DEV     = 4,
  parameter int DATA_W    = 32,
  parameter int SPAN_LOG2 = 4
);
  logic [N_DEV-1:0]        dev_sel;
  logic                    dev_read;
  logic                    dev_write;
  logic [SPAN_LOG2-1:0]    dev_addr;
  logic [DATA_W-1:0]       dev_wdata;
  logic [N_DEV*DATA_W-1:0] dev_rdata;
  logic [N_DEV-1:0]        dev_ready;

  modport master (
    output dev_sel, dev_read, dev_write, dev_addr, dev_wdata,
    input  dev_rdata, dev_ready
  );

  modport slave (
    input  dev_sel, dev_read, dev_write, dev_addr, dev_wdata,
    output dev_rdata, dev_ready
  );
endinterface

// File: rtl/membus_bridge.sv
// ---------------------------------------------------------------------------
// membus_bridge
//
// Bridges CPU device accesses (addresses at or above DEV_BASE) onto N_DEV
// memory-mapped peripheral slots with per-slot selects and a ready handshake
// allowing wait states. The CPU is stalled until the access completes.
//
// Ports:
//   clk        clock, all state changes on rising edge
//   reset      synchronous, active-high
//   cpu        cpu_bus_if.slave  : cpu_read/cpu_write/cpu_addr/cpu_wdata in,
//                                  cpu_rdata/cpu_stall/cpu_err out
//   dev        dev_bus_if.master : dev_sel/dev_read/dev_write/dev_addr/
//                                  dev_wdata out, dev_rdata/dev_ready in
//   dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 DONE)
//
// Optional feature macro: BRIDGE_TIMEOUT_EN
//   When defined, an access waiting TIMEOUT cycles without ready is
//   terminated with an error response. When undefined, WAIT persists until
//   ready or reset and TIMEOUT is unused.
// ---------------------------------------------------------------------------
module membus_bridge #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              N_DEV     = 4,
  parameter logic [ADDR_W-1:0] DEV_BASE = 32'h40000000,
  parameter int              SPAN_LOG2 = 4,
  parameter int              TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  cpu_bus_if.slave   cpu,
  dev_bus_if.master  dev,
  output logic [1:0] dbg_state
);

  localparam int SLOT_W = $clog2(N_DEV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [N_DEV-1:0]     sel_q, sel_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [SPAN_LOG2-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Request decode on the live CPU inputs; only used in IDLE.
  logic [ADDR_W-1:0] req_offset;
  logic [SLOT_W-1:0] req_slot;
  logic              req_any;
  logic              req_mapped;
  logic              req_single;

  assign req_any    = cpu.cpu_read | cpu.cpu_write;
  assign req_single = cpu.cpu_read ^ cpu.cpu_write;
  assign req_offset = cpu.cpu_addr - DEV_BASE;
  assign req_slot   = req_offset[SPAN_LOG2 +: SLOT_W];
  // In range when at/above the base and no offset bits above the slot field.
  assign req_mapped = (cpu.cpu_addr >= DEV_BASE) &&
                      ((req_offset >> (SPAN_LOG2 + SLOT_W)) == '0);

  // Read data of the captured slot.
  logic [DATA_W-1:0] slot_rdata;
  always_comb begin
    slot_rdata = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (slot_q == SLOT_W'(i)) slot_rdata = dev.dev_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (req_mapped && req_single) begin
            state_d = WAIT;
            slot_d  = req_slot;
            sel_d   = {{(N_DEV-1){1'b0}}, 1'b1} << req_slot;
            rd_d    = cpu.cpu_read;
            wr_d    = cpu.cpu_write;
            addr_d  = req_offset[SPAN_LOG2-1:0];
            wdata_d = cpu.cpu_wdata;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // Unmapped or ambiguous request: answer with error, never strobe.
            state_d = DONE;
            rdata_d = '1;
            err_d   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (dev.dev_ready[slot_q]) begin
          state_d = DONE;
          rdata_d = rd_q ? slot_rdata : '0;
          err_d   = 1'b0;
          sel_d   = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
`ifdef BRIDGE_TIMEOUT_EN
        // Ready in the same cycle as the limit takes priority (branch above).
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          rdata_d = '1;
          err_d   = 1'b1;
          sel_d   = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        // A request still held here is the one just answered; not replayed.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      sel_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign cpu.cpu_stall = req_any & (state_q != DONE) & ~reset;
  assign cpu.cpu_rdata = rdata_q;
  assign cpu.cpu_err   = err_q;

  assign dev.dev_sel   = sel_q;
  assign dev.dev_read  = rd_q;
  assign dev.dev_write = wr_q;
  assign dev.dev_addr  = addr_q;
  assign dev.dev_wdata = wdata_q;

  assign dbg_state = state_q;

endmodule
